// File: rtl/ieeedrv_pkg.sv
// Constants and error codes shared by the drive's track generator and track parser.
package ieeedrv_pkg;

    localparam logic [7:0] HDR_CODE  = 8'h08;
    localparam logic [7:0] DATA_CODE = 8'h07;
    localparam logic [7:0] TEST_CODE = 8'h0F;
    localparam logic [7:0] SYNC_BYTE = 8'h42;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_HDR_CHK  = 3'd1,
        ERR_TRACK    = 3'd2,
        ERR_DATA_CHK = 3'd3,
        ERR_SHORT    = 3'd4,
        ERR_NO_HDR   = 3'd5,
        ERR_UNKNOWN  = 3'd6,
        ERR_SECTOR   = 3'd7
    } err_code_t;

endpackage

// File: rtl/ieeedrv_trkparse.sv
// Receive-side track stream parser: finds sync runs and block codes, checks header and
// data blocks, and writes 256-byte data payloads into the sector buffer.
module ieeedrv_trkparse #(
    parameter int unsigned MIN_SYNC  = 2,
    parameter logic [7:0]  HDR_CODE  = ieeedrv_pkg::HDR_CODE,
    parameter logic [7:0]  DATA_CODE = ieeedrv_pkg::DATA_CODE
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  track,
    input  logic        byte_stb,
    input  logic        sync_n,
    input  logic [7:0]  byte_in,
    output logic        hdr_stb,
    output logic [4:0]  hdr_sector,
    output logic [15:0] hdr_id,
    output logic        data_stb,
    output logic [12:0] buf_addr,
    output logic [7:0]  buf_data,
    output logic        buf_we,
    output logic        err_stb,
    output logic [2:0]  err_code,
    output logic        busy
);
    import ieeedrv_pkg::*;

    typedef enum logic [2:0] {HUNT, SYNC, HDR, DATA, DCHK} state_t;

    localparam logic [2:0] MIN_SYNC_C = 3'(MIN_SYNC);

    state_t     state_q, state_d;
    logic [2:0] sync_cnt_q, sync_cnt_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] hchk_q, hchk_d, hsec_q, hsec_d, htrk_q, htrk_d, hidhi_q, hidhi_d;
    logic       hdr_ok_q, hdr_ok_d;

    logic        hdr_stb_d, data_stb_d, err_stb_d, buf_we_d, busy_d;
    logic [4:0]  hdr_sector_d;
    logic [15:0] hdr_id_d;
    logic [12:0] buf_addr_d;
    logic [7:0]  buf_data_d;
    err_code_t   err_code_q, err_code_d;

    logic      enough_sync;
    err_code_t hdr_verdict;

    assign enough_sync = (sync_cnt_q >= MIN_SYNC_C);

    // Header verdict on the final byte (id_lo on byte_in); priority checksum, track, sector.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        hdr_verdict = ERR_NONE;
        if ((acc_q ^ byte_in) != hchk_q)
            hdr_verdict = ERR_HDR_CHK;
        else if (htrk_q != track)
            hdr_verdict = ERR_TRACK;
        else if (hsec_q[7:5] != 3'd0)
            hdr_verdict = ERR_SECTOR;
    end

    always_ff @(posedge clk_sys) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q    <= HUNT;
            sync_cnt_q <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            hchk_q     <= '0;
            hsec_q     <= '0;
            htrk_q     <= '0;
            hidhi_q    <= '0;
            hdr_ok_q   <= 1'b0;
            hdr_stb    <= 1'b0;
            hdr_sector <= '0;
            hdr_id     <= '0;
            data_stb   <= 1'b0;
            buf_addr   <= '0;
            buf_data   <= '0;
            buf_we     <= 1'b0;
            err_stb    <= 1'b0;
            err_code_q <= ERR_NONE;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_cnt_q <= sync_cnt_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            hchk_q     <= hchk_d;
            hsec_q     <= hsec_d;
            htrk_q     <= htrk_d;
            hidhi_q    <= hidhi_d;
            hdr_ok_q   <= hdr_ok_d;
            hdr_stb    <= hdr_stb_d;
            hdr_sector <= hdr_sector_d;
            hdr_id     <= hdr_id_d;
            data_stb   <= data_stb_d;
            buf_addr   <= buf_addr_d;
            buf_data   <= buf_data_d;
            buf_we     <= buf_we_d;
            err_stb    <= err_stb_d;
            err_code_q <= err_code_d;
            busy       <= busy_d;
        end
    end

    assign err_code = err_code_q;

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = HUNT;
        end else if (byte_stb) begin
            case (state_q)
                HUNT: if (!sync_n) state_d = SYNC;
                SYNC: begin
                    if (sync_n) begin
                        if (enough_sync && byte_in == HDR_CODE)
                            state_d = HDR;
                        else if (enough_sync && byte_in == DATA_CODE && hdr_ok_q)
                            state_d = DATA;
                        else
                            state_d = HUNT;
                    end
                end
                HDR:  if (!sync_n) state_d = SYNC; else if (idx_q == 8'd4) state_d = HUNT;
                DATA: if (!sync_n) state_d = SYNC; else if (idx_q == 8'hFF) state_d = DCHK;
                DCHK: state_d = sync_n ? HUNT : SYNC;
                default: state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        sync_cnt_d   = sync_cnt_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        hchk_d       = hchk_q;
        hsec_d       = hsec_q;
        htrk_d       = htrk_q;
        hidhi_d      = hidhi_q;
        hdr_ok_d     = hdr_ok_q;
        hdr_stb_d    = 1'b0;
        hdr_sector_d = hdr_sector;
        hdr_id_d     = hdr_id;
        data_stb_d   = 1'b0;
        buf_addr_d   = buf_addr;
        buf_data_d   = buf_data;
        buf_we_d     = 1'b0;
        err_stb_d    = 1'b0;
        err_code_d   = err_code_q;

        if (!enable) begin
            hdr_ok_d   = 1'b0;
            sync_cnt_d = '0;
        end else if (byte_stb) begin
            if (!sync_n && (state_q == HDR || state_q == DATA || state_q == DCHK)) begin
                // A sync inside a block truncates it; that sync also opens a new run.
                err_stb_d  = 1'b1;
                err_code_d = ERR_SHORT;
                hdr_ok_d   = 1'b0;
                sync_cnt_d = 3'd1;
            end else begin
                case (state_q)
                    HUNT: if (!sync_n) sync_cnt_d = 3'd1;
                    SYNC: begin
                        if (!sync_n) begin
                            if (sync_cnt_q != 3'd7) sync_cnt_d = sync_cnt_q + 3'd1;
                        end else if (enough_sync) begin
                            idx_d = '0;
                            acc_d = '0;
                            if (byte_in != HDR_CODE) begin
                                if (byte_in == DATA_CODE) begin
                                    if (!hdr_ok_q) begin
                                        err_stb_d  = 1'b1;
                                        err_code_d = ERR_NO_HDR;
                                    end
                                end else begin
                                    err_stb_d  = 1'b1;
                                    err_code_d = ERR_UNKNOWN;
                                end
                            end
                        end
                    end
                    HDR: begin
                        idx_d = idx_q + 8'd1;
                        if (idx_q != 8'd0) acc_d = acc_q ^ byte_in;
                        case (idx_q)
                            8'd0: hchk_d  = byte_in;
                            8'd1: hsec_d  = byte_in;
                            8'd2: htrk_d  = byte_in;
                            8'd3: hidhi_d = byte_in;
                            default: ;
                        endcase
                        if (idx_q == 8'd4) begin
                            if (hdr_verdict != ERR_NONE) begin
                                err_stb_d  = 1'b1;
                                err_code_d = hdr_verdict;
                                hdr_ok_d   = 1'b0;
                            end else begin
                                hdr_ok_d     = 1'b1;
                                hdr_stb_d    = 1'b1;
                                hdr_sector_d = hsec_q[4:0];
                                hdr_id_d     = {hidhi_q, byte_in};
                            end
                        end
                    end
                    DATA: begin
                        buf_we_d   = 1'b1;
                        buf_addr_d = {hdr_sector, idx_q};
                        buf_data_d = byte_in;
                        acc_d      = acc_q ^ byte_in;
                        idx_d      = idx_q + 8'd1;
                    end
                    DCHK: begin
                        hdr_ok_d = 1'b0;
                        if (byte_in == acc_q) begin
                            data_stb_d = 1'b1;
                        end else begin
                            err_stb_d  = 1'b1;
                            err_code_d = ERR_DATA_CHK;
                        end
                    end
                    default: ;
                endcase
            end
        end

        // A sync run long enough to accept a code counts as the code-wait phase.
        busy_d = (state_d == HDR) || (state_d == DATA) || (state_d == DCHK) ||
                 ((state_d == SYNC) && (sync_cnt_d >= MIN_SYNC_C));
    end

endmodule

// File: tb/tb_ieeedrv_trkparse.sv
// Directed bench for ieeedrv_trkparse: headers, data blocks, error codes, reset and enable.
module tb_ieeedrv_trkparse;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [7:0]  track = 8'h12;
    logic        byte_stb = 1'b0;
    logic        sync_n = 1'b1;
    logic [7:0]  byte_in = 8'h00;
    logic        hdr_stb;
    logic [4:0]  hdr_sector;
    logic [15:0] hdr_id;
    logic        data_stb;
    logic [12:0] buf_addr;
    logic [7:0]  buf_data;
    logic        buf_we;
    logic        err_stb;
    logic [2:0]  err_code;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int          hdr_cnt = 0;
    int          data_cnt = 0;
    int          err_cnt = 0;
    logic [2:0]  last_err = 3'd0;
    logic [12:0] wr_addr[$];
    logic [7:0]  wr_data[$];

    always #5 clk_sys = ~clk_sys;

    ieeedrv_trkparse #(.MIN_SYNC(2)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .enable    (enable),
        .track     (track),
        .byte_stb  (byte_stb),
        .sync_n    (sync_n),
        .byte_in   (byte_in),
        .hdr_stb   (hdr_stb),
        .hdr_sector(hdr_sector),
        .hdr_id    (hdr_id),
        .data_stb  (data_stb),
        .buf_addr  (buf_addr),
        .buf_data  (buf_data),
        .buf_we    (buf_we),
        .err_stb   (err_stb),
        .err_code  (err_code),
        .busy      (busy)
    );

    // Event recorder, sampled on the falling edge away from the register updates.
    always @(negedge clk_sys) begin
        if (buf_we) begin
            wr_addr.push_back(buf_addr);
            wr_data.push_back(buf_data);
        end
        if (hdr_stb) hdr_cnt++;
        if (data_stb) data_cnt++;
        if (err_stb) begin
            err_cnt++;
            last_err = err_code;
        end
    end

    task automatic send_byte(input logic sn, input logic [7:0] b);
        @(negedge clk_sys);
        byte_stb = 1'b1;
        sync_n   = sn;
        byte_in  = b;
        @(negedge clk_sys);
        byte_stb = 1'b0;
        sync_n   = 1'b1;
        #1;
    endtask

    task automatic send_syncs(input int n);
        for (int i = 0; i < n; i++) send_byte(1'b0, 8'h42);
    endtask

    task automatic send_hdr(input int nsync, input logic [7:0] c, input logic [7:0] s,
                            input logic [7:0] t, input logic [7:0] hi, input logic [7:0] lo);
        send_syncs(nsync);
        send_byte(1'b1, 8'h08);
        send_byte(1'b1, c);
        send_byte(1'b1, s);
        send_byte(1'b1, t);
        send_byte(1'b1, hi);
        send_byte(1'b1, lo);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_sys);
        #1;
        checks++;
        if ({hdr_stb, data_stb, buf_we, err_stb, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_pulses: got %b expected 00000", {hdr_stb, data_stb, buf_we, err_stb, busy});
        end
        checks++;
        if ({hdr_sector, hdr_id, buf_addr, buf_data, err_code} !== 45'd0) begin
            errors++;
            $display("FAIL reset_values: got sec=%h id=%h addr=%h data=%h err=%0d expected all 0",
                     hdr_sector, hdr_id, buf_addr, buf_data, err_code);
        end
        reset = 1'b0;
    endtask

    task automatic test_header();
        int h0 = hdr_cnt;
        int e0 = err_cnt;
        send_syncs(3);
        send_byte(1'b1, 8'h08);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL hdr_busy: got %b expected 1", busy);
        end
        send_byte(1'b1, 8'h12);
        send_byte(1'b1, 8'h03);
        send_byte(1'b1, 8'h12);
        send_byte(1'b1, 8'h41);
        send_byte(1'b1, 8'h42);
        checks++;
        if (hdr_cnt - h0 !== 1) begin
            errors++;
            $display("FAIL hdr_stb_count: got %0d expected 1", hdr_cnt - h0);
        end
        checks++;
        if (hdr_sector !== 5'd3 || hdr_id !== 16'h4142) begin
            errors++;
            $display("FAIL hdr_fields: got sec=%0d id=%h expected sec=3 id=4142", hdr_sector, hdr_id);
        end
        checks++;
        if (err_cnt - e0 !== 0) begin
            errors++;
            $display("FAIL hdr_no_err: got %0d errors expected 0", err_cnt - e0);
        end
    endtask

    task automatic test_data();
        int d0 = data_cnt;
        int e0 = err_cnt;
        int w0 = wr_addr.size();
        send_syncs(3);
        send_byte(1'b1, 8'h07);
        for (int i = 0; i < 256; i++) send_byte(1'b1, 8'(i));
        send_byte(1'b1, 8'h00);
        checks++;
        if (wr_addr.size() - w0 !== 256) begin
            errors++;
            $display("FAIL data_write_count: got %0d expected 256", wr_addr.size() - w0);
        end else begin
            for (int i = 0; i < 256; i++) begin
                checks++;
                if (wr_addr[w0 + i] !== 13'h300 + 13'(i) || wr_data[w0 + i] !== 8'(i)) begin
                    errors++;
                    $display("FAIL data_write_%0d: got addr=%h data=%h expected addr=%h data=%h",
                             i, wr_addr[w0 + i], wr_data[w0 + i], 13'h300 + 13'(i), 8'(i));
                end
            end
        end
        checks++;
        if (data_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
            errors++;
            $display("FAIL data_stb: got data=%0d err=%0d expected data=1 err=0", data_cnt - d0, err_cnt - e0);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL data_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_data_chk_err();
        int d0 = data_cnt;
        int e0;
        int w0;
        send_hdr(3, 8'h12, 8'h03, 8'h12, 8'h41, 8'h42);
        e0 = err_cnt;
        send_syncs(3);
        send_byte(1'b1, 8'h07);
        for (int i = 0; i < 256; i++) send_byte(1'b1, 8'(i));
        send_byte(1'b1, 8'h01);
        checks++;
        if (err_cnt - e0 !== 1 || last_err !== 3'd3 || data_cnt - d0 !== 0) begin
            errors++;
            $display("FAIL data_chk_err: got err=%0d code=%0d data=%0d expected err=1 code=3 data=0",
                     err_cnt - e0, last_err, data_cnt - d0);
        end
        e0 = err_cnt;
        w0 = wr_addr.size();
        send_syncs(3);
        send_byte(1'b1, 8'h07);
        send_byte(1'b1, 8'hAA);
        checks++;
        if (err_cnt - e0 !== 1 || last_err !== 3'd5 || wr_addr.size() - w0 !== 0) begin
            errors++;
            $display("FAIL data_no_hdr: got err=%0d code=%0d writes=%0d expected err=1 code=5 writes=0",
                     err_cnt - e0, last_err, wr_addr.size() - w0);
        end
    endtask

    task automatic test_hdr_errors();
        int h0 = hdr_cnt;
        int e0 = err_cnt;
        send_hdr(3, 8'h13, 8'h03, 8'h13, 8'h41, 8'h42);
        checks++;
        if (err_cnt - e0 !== 1 || last_err !== 3'd2) begin
            errors++;
            $display("FAIL hdr_track: got err=%0d code=%0d expected err=1 code=2", err_cnt - e0, last_err);
        end
        send_hdr(3, 8'h12, 8'h03, 8'h13, 8'h41, 8'h42);
        checks++;
        if (err_cnt - e0 !== 2 || last_err !== 3'd1) begin
            errors++;
            $display("FAIL hdr_chk: got err=%0d code=%0d expected err=2 code=1", err_cnt - e0, last_err);
        end
        send_hdr(3, 8'h32, 8'h23, 8'h12, 8'h41, 8'h42);
        checks++;
        if (err_cnt - e0 !== 3 || last_err !== 3'd7) begin
            errors++;
            $display("FAIL hdr_sector: got err=%0d code=%0d expected err=3 code=7", err_cnt - e0, last_err);
        end
        checks++;
        if (hdr_cnt - h0 !== 0 || hdr_sector !== 5'd3) begin
            errors++;
            $display("FAIL hdr_err_hold: got hdr=%0d sec=%0d expected hdr=0 sec=3", hdr_cnt - h0, hdr_sector);
        end
    endtask

    task automatic test_short_block();
        int e0;
        int h0;
        int w0;
        send_hdr(3, 8'h14, 8'h05, 8'h12, 8'h41, 8'h42);
        e0 = err_cnt;
        w0 = wr_addr.size();
        send_syncs(3);
        send_byte(1'b1, 8'h07);
        for (int i = 0; i < 100; i++) send_byte(1'b1, 8'(i + 7));
        send_byte(1'b0, 8'h42);
        checks++;
        if (err_cnt - e0 !== 1 || last_err !== 3'd4) begin
            errors++;
            $display("FAIL short_err: got err=%0d code=%0d expected err=1 code=4", err_cnt - e0, last_err);
        end
        checks++;
        if (wr_addr.size() - w0 !== 100 || wr_addr[$] !== 13'h563 || wr_data[$] !== 8'h6A) begin
            errors++;
            $display("FAIL short_writes: got n=%0d last=%h/%h expected n=100 last=0563/6a",
                     wr_addr.size() - w0, wr_addr[$], wr_data[$]);
        end
        h0 = hdr_cnt;
        send_hdr(1, 8'hEA, 8'h07, 8'h12, 8'hA5, 8'h5A);
        checks++;
        if (hdr_cnt - h0 !== 1 || hdr_sector !== 5'd7 || hdr_id !== 16'hA55A || err_cnt - e0 !== 1) begin
            errors++;
            $display("FAIL short_reparse: got hdr=%0d sec=%0d id=%h err=%0d expected hdr=1 sec=7 id=a55a err=1",
                     hdr_cnt - h0, hdr_sector, hdr_id, err_cnt - e0);
        end
    endtask

    task automatic test_single_sync();
        int h0 = hdr_cnt;
        int e0 = err_cnt;
        send_syncs(1);
        send_byte(1'b1, 8'h08);
        send_byte(1'b1, 8'h12);
        send_byte(1'b1, 8'h03);
        send_byte(1'b1, 8'h12);
        send_byte(1'b1, 8'h41);
        send_byte(1'b1, 8'h42);
        checks++;
        if (hdr_cnt - h0 !== 0 || err_cnt - e0 !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_sync: got hdr=%0d err=%0d busy=%b expected 0 0 0",
                     hdr_cnt - h0, err_cnt - e0, busy);
        end
    endtask

    task automatic test_reset_mid_block();
        int w0;
        int e0;
        send_hdr(3, 8'h12, 8'h03, 8'h12, 8'h41, 8'h42);
        w0 = wr_addr.size();
        send_syncs(3);
        send_byte(1'b1, 8'h07);
        for (int i = 0; i < 50; i++) send_byte(1'b1, 8'(i));
        @(negedge clk_sys);
        byte_stb = 1'b1;
        sync_n   = 1'b1;
        byte_in  = 8'd50;
        reset    = 1'b1;
        @(negedge clk_sys);
        byte_stb = 1'b0;
        #1;
        checks++;
        if ({hdr_stb, data_stb, buf_we, err_stb, busy, hdr_sector, hdr_id, buf_addr, buf_data, err_code} !== 50'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got we=%b addr=%h data=%h sec=%0d expected all 0",
                     buf_we, buf_addr, buf_data, hdr_sector);
        end
        reset = 1'b0;
        for (int i = 51; i < 71; i++) send_byte(1'b1, 8'(i));
        checks++;
        if (wr_addr.size() - w0 !== 50) begin
            errors++;
            $display("FAIL reset_mid_writes: got %0d expected 50", wr_addr.size() - w0);
        end
        e0 = err_cnt;
        send_syncs(3);
        send_byte(1'b1, 8'h0F);
        checks++;
        if (err_cnt - e0 !== 1 || last_err !== 3'd6) begin
            errors++;
            $display("FAIL unknown_code: got err=%0d code=%0d expected err=1 code=6", err_cnt - e0, last_err);
        end
    endtask

    task automatic test_enable();
        int e0;
        int w0;
        send_hdr(3, 8'h12, 8'h03, 8'h12, 8'h41, 8'h42);
        @(negedge clk_sys);
        enable = 1'b0;
        @(negedge clk_sys);
        enable = 1'b1;
        e0 = err_cnt;
        w0 = wr_addr.size();
        send_syncs(3);
        send_byte(1'b1, 8'h07);
        send_byte(1'b1, 8'h55);
        checks++;
        if (err_cnt - e0 !== 1 || last_err !== 3'd5 || wr_addr.size() - w0 !== 0) begin
            errors++;
            $display("FAIL enable_clears_hdr: got err=%0d code=%0d writes=%0d expected err=1 code=5 writes=0",
                     err_cnt - e0, last_err, wr_addr.size() - w0);
        end
    endtask

    initial begin
        test_reset();
        test_header();
        test_data();
        test_data_chk_err();
        test_hdr_errors();
        test_short_block();
        test_single_sync();
        test_reset_mid_block();
        test_enable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ieeedrv_trkparse.md
Name: ieeedrv_trkparse

Overview:
Receive-side decoder for the drive's GCR-less byte-level track stream: consumes byte strobes with a sync flag and recognises sync runs, block codes, header blocks and 256-byte data blocks. Validates checksums and track number, then writes data payloads into the sector buffer through a 13-bit write port. It is the receiver counterpart to the track generator. It sits between the controller-side write byte path and the sector buffer; it also serves as a stream monitor in simulation.

Parameters:
MIN_SYNC, 2, minimum consecutive sync bytes before a block code is accepted (1..7)
HDR_CODE, 8'h08, block code for a header block
DATA_CODE, 8'h07, block code for a data block

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high; clock clk_sys
enable  in  1  0 = hold in HUNT, ignore strobes, no writes
track  in  8  expected track for header comparison
byte_stb  in  1  one-cycle strobe: byte_in/sync_n valid
sync_n  in  1  0 = current byte is a sync byte
byte_in  in  8  stream byte
hdr_stb  out  1  one-cycle pulse: valid header decoded
hdr_sector  out  5  sector from last valid header
hdr_id  out  16  {id_hi, id_lo} from last valid header
data_stb  out  1  one-cycle pulse: data block complete, checksum good
buf_addr  out  13  {hdr_sector, byte index}
buf_data  out  8  write data
buf_we  out  1  buffer write enable, one cycle per payload byte
err_stb  out  1  one-cycle error pulse
err_code  out  3  1 hdr checksum, 2 track mismatch, 3 data checksum, 4 short block, 5 data without header, 6 unknown code, 7 bad sector field
busy  out  1  1 in CODE/HDR/DATA/DCHK

Behaviour:
- All outputs registered; reset: every output 0, state HUNT, sync_cnt 0, hdr_ok 0.
- Only byte_stb cycles advance the FSM; response appears on the cycle after the strobe (latency 1). Pulses last exactly one clk_sys.
- HUNT: strobe with sync_n=0 -> sync_cnt=1, SYNC; otherwise stay.
- SYNC: sync_n=0 -> sync_cnt saturating increment (3-bit). sync_n=1 with sync_cnt<MIN_SYNC -> HUNT, no error. Otherwise the byte is the block code: HDR_CODE -> HDR, idx=0; DATA_CODE -> if hdr_ok, DATA, idx=0, else err 5, HUNT; any other code -> err 6, HUNT.
- HDR: 5 bytes in order chk, sector, track, id_hi, id_lo. Running XOR is taken over bytes 1..4. After byte 4: XOR≠chk -> err 1; else track byte≠track -> err 2; else sector byte[7:5]≠0 -> err 7; else latch sector/id, hdr_ok=1, hdr_stb. Priority order is 1, 2, 7. Any error clears hdr_ok. Next state HUNT; gap bytes are ignored there.
- DATA: each non-sync byte -> buf_we=1, buf_addr={hdr_sector,idx}, buf_data=byte, chk^=byte, idx++ (8-bit). Byte 255 -> DCHK.
- DCHK: next byte compared with chk: equal -> data_stb; else err 3. Always clear hdr_ok (one data block per header), HUNT.
- Sync byte during HDR/DATA/DCHK -> err 4, hdr_ok=0, state SYNC with sync_cnt=1 (the new sync run counts).
- enable=0: state forced HUNT, hdr_ok=0, buf_we=0; pending pulses are not generated.
- Reset mid-block: no further buf_we; writes already issued are not undone.
- Simultaneous reset and byte_stb: reset wins.

Decomposition:
- Shared package ieeedrv_pkg: block codes (HDR_CODE 8'h08, DATA_CODE 8'h07, TEST_CODE 8'h0F, SYNC_BYTE 8'h42) and the err_code enum. The track generator is migrated to the same constants.
- Parser state enum {HUNT, SYNC, HDR, DATA, DCHK} is local to this module.
- No sub-module; a single FSM with an XOR accumulator.

Test Plan:
- 3 sync, 08, 12 03 12 41 42 with track=18 -> hdr_stb, hdr_sector=3, hdr_id=16'h4142, no err_stb.
- The above, then 3 sync, 07, bytes 00..FF, 00 -> 256 buf_we with buf_addr 13'h300..13'h3FF, data_stb, buf_data matches.
- The same sequence with checksum byte 01 -> err_stb, err_code=3, no data_stb, hdr_ok cleared; a following data block -> err 5.
- Header with track byte 0x13 and checksum fixed up, track=18 -> err_code=2; header checksum wrong -> err_code=1 (checked first).
- Sync byte injected after data byte 100 -> err_code=4, exactly 100 writes, then a valid header re-parses correctly; single sync with MIN_SYNC=2 -> silent return to HUNT.
- Reset asserted at data byte 50 -> all outputs 0 next cycle, no further buf_we; code 0x0F -> err_code=6.
